// File: rtl/vslc_stack_executor_if.sv
// Instruction byte stream and parameter-write strobe bundle for the VSLC
// stack executor. The master side presents instruction bytes and observes
// the parameter strobe; the slave side is the executor itself.
interface vslc_stack_executor_if;
   logic       instr_valid;
   logic [7:0] instr;
   logic       instr_ready;
   logic       param_we;
   logic [2:0] param_addr;
   logic [7:0] param_data;

   modport master (
      output instr_valid,
      output instr,
      input  instr_ready,
      input  param_we,
      input  param_addr,
      input  param_data
   );

   modport slave (
      input  instr_valid,
      input  instr,
      output instr_ready,
      output param_we,
      output param_addr,
      output param_data
   );
endinterface

// File: rtl/vslc_stack_executor.sv
// vslc_stack_executor: one-bit-wide stack machine for PLC-style ladder
// programs. One instruction byte is consumed per accepted handshake; the
// input image is captured on scan_start. A parameter prefix byte either
// routes the following byte to the parameter strobe or discards it.
// Optional feature macro: VSLC_STACK_FLAGS_EN adds the sticky stack_fault
// output (overflow / operand underflow, cleared by rst or CLR).
module vslc_stack_executor #(
   parameter  int STACK_DEPTH = 8,
   parameter  int IO_WIDTH    = 8,
   parameter  int SFR_WIDTH   = 16,
   localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   vslc_stack_executor_if.slave    bus,
   input  logic                    scan_start,
   input  logic [IO_WIDTH-1:0]     ui_in,
   input  logic [SFR_WIDTH-1:0]    sfr_in,
   output logic [IO_WIDTH-1:0]     uo_out,
   output logic [SFR_WIDTH-1:0]    sfr_out,
   output logic                    tos,
   output logic [DEPTH_W-1:0]      stack_depth
`ifdef VSLC_STACK_FLAGS_EN
   ,
   output logic                    stack_fault
`endif
);

   typedef enum logic [1:0] {ST_EXEC, ST_PLOAD, ST_PSKIP} state_t;

   state_t                 state_q, state_nx;
   logic                   ready_q;
   logic [STACK_DEPTH-1:0] stk_q, stk_nx;
   logic [DEPTH_W-1:0]     depth_q, depth_nx;
   logic [IO_WIDTH-1:0]    img_q, prev_q, uo_q;
   logic [SFR_WIDTH-1:0]   sfr_q;
   logic [2:0]             slot_q;
   logic                   pwe_q, pwe_nx;
   logic [2:0]             paddr_q, paddr_nx;
   logic [7:0]             pdata_q, pdata_nx;

   // Register files padded to the full encodable index range; out-of-range
   // reads see 0 and out-of-range writes fall off when truncated back.
   logic [7:0]             img_pad, prev_pad, uo_pad, uo_pad_nx;
   logic [15:0]            sfr_in_pad, sfr_pad, sfr_pad_nx;

   logic [7:0]             op;
   logic                   accept, exec_en, is_prefix;
   logic                   inc, dec, clr, set_all;
   logic [3:0]             tt;
   logic [1:0]             lidx;
   logic                   res, edge_bit;

   assign op         = bus.instr;
   assign accept     = bus.instr_valid && ready_q;
   assign exec_en    = accept && (state_q == ST_EXEC);
   assign is_prefix  = (op[7:4] == 4'b1110);

   assign img_pad    = 8'(img_q);
   assign prev_pad   = 8'(prev_q);
   assign uo_pad     = 8'(uo_q);
   assign sfr_in_pad = 16'(sfr_in);
   assign sfr_pad    = 16'(sfr_q);

   function automatic logic [STACK_DEPTH-1:0] f_push(input logic [STACK_DEPTH-1:0] s,
                                                     input logic b);
      return {s[STACK_DEPTH-2:0], b};
   endfunction

   function automatic logic [STACK_DEPTH-1:0] f_pop(input logic [STACK_DEPTH-1:0] s);
      return {1'b0, s[STACK_DEPTH-1:1]};
   endfunction

   // Register write rule: 01 copy, 10 set-if-tos, 11 clear-if-tos.
   function automatic logic f_wr(input logic [1:0] oo, input logic old, input logic t);
      logic v;
      case (oo)
         2'b01:   v = t;
         2'b10:   v = old | t;
         2'b11:   v = old & ~t;
         default: v = old;
      endcase
      return v;
   endfunction

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EXEC;
      else     state_q <= state_nx;
   end

   // FSM next state: a prefix picks load or skip, the following byte returns to EXEC
   always_comb begin
      state_nx = state_q;
      if (accept) begin
         case (state_q)
            ST_EXEC: begin
               if (is_prefix) state_nx = (stk_q[0] == op[3]) ? ST_PLOAD : ST_PSKIP;
            end
            default: state_nx = ST_EXEC;
         endcase
      end
   end

   // FSM outputs: parameter strobe fields for the byte following a loading prefix
   always_comb begin
      pwe_nx   = accept && (state_q == ST_PLOAD);
      paddr_nx = pwe_nx ? slot_q : paddr_q;
      pdata_nx = pwe_nx ? op     : pdata_q;
   end

   // Instruction decode and execution of stack, register and depth updates
   always_comb begin
      stk_nx     = stk_q;
      uo_pad_nx  = uo_pad;
      sfr_pad_nx = sfr_pad;
      inc        = 1'b0;
      dec        = 1'b0;
      clr        = 1'b0;
      set_all    = 1'b0;
      tt         = op[3:0];
      lidx       = ~{stk_q[1], stk_q[0]};
      res        = tt[lidx];
      edge_bit   = (img_pad[op[2:0]] == ~op[4]) && (prev_pad[op[2:0]] == op[4]);
      if (exec_en) begin
         if (!op[7]) begin
            // op[6] selects SFR (0 1 oo ssss) over I/O (00 oo i rrr)
            if (op[5:4] == 2'b00) begin
               inc    = 1'b1;
               stk_nx = f_push(stk_q, op[6] ? sfr_in_pad[op[3:0]]
                                            : (op[3] ? uo_pad[op[2:0]] : img_pad[op[2:0]]));
            end else begin
               dec    = 1'b1;
               stk_nx = f_pop(stk_q);
               if (op[6]) sfr_pad_nx[op[3:0]] = f_wr(op[5:4], sfr_pad[op[3:0]], stk_q[0]);
               else       uo_pad_nx[op[2:0]]  = f_wr(op[5:4], uo_pad[op[2:0]], stk_q[0]);
            end
         end else if (!op[6]) begin
            case (op[5:4])
               2'b01: begin
                  dec    = 1'b1;
                  stk_nx = {1'b0, stk_q[STACK_DEPTH-1:2], res};
               end
               2'b11: begin
                  inc    = 1'b1;
                  stk_nx = f_push(stk_q, res);
               end
               default: stk_nx[0] = res;
            endcase
         end else if (!op[5]) begin
            inc    = 1'b1;
            stk_nx = f_push(stk_q, edge_bit);
         end else if (op[4]) begin
            case (op[3:0])
               4'h0: begin clr = 1'b1; stk_nx = '0; end
               4'h1: begin set_all = 1'b1; stk_nx = '1; end
               4'h2: stk_nx[1:0] = {stk_q[0], stk_q[1]};
               4'h3: stk_nx[2:0] = {stk_q[0], stk_q[2], stk_q[1]};
               4'h4: begin inc = 1'b1; stk_nx = f_push(stk_q, stk_q[0]); end
               4'h5: begin dec = 1'b1; stk_nx = f_pop(stk_q); end
               default: stk_nx = stk_q;
            endcase
         end
      end
      if (clr)                                             depth_nx = '0;
      else if (set_all)                                    depth_nx = DEPTH_W'(STACK_DEPTH);
      else if (inc && (depth_q != DEPTH_W'(STACK_DEPTH)))  depth_nx = depth_q + DEPTH_W'(1);
      else if (dec && (depth_q != '0))                     depth_nx = depth_q - DEPTH_W'(1);
      else                                                 depth_nx = depth_q;
   end

   // Datapath, image capture and strobe registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= 1'b0;
         stk_q   <= '0;
         depth_q <= '0;
         img_q   <= '0;
         prev_q  <= '0;
         uo_q    <= '0;
         sfr_q   <= '0;
         slot_q  <= '0;
         pwe_q   <= 1'b0;
         paddr_q <= '0;
         pdata_q <= '0;
      end else begin
         ready_q <= 1'b1;
         stk_q   <= stk_nx;
         depth_q <= depth_nx;
         uo_q    <= IO_WIDTH'(uo_pad_nx);
         sfr_q   <= SFR_WIDTH'(sfr_pad_nx);
         pwe_q   <= pwe_nx;
         paddr_q <= paddr_nx;
         pdata_q <= pdata_nx;
         if (exec_en && is_prefix) slot_q <= op[2:0];
         if (scan_start) begin
            img_q  <= ui_in;
            prev_q <= img_q;
         end
      end
   end

`ifdef VSLC_STACK_FLAGS_EN
   logic fault_q;

   // Operands each instruction expects to find on the stack.
   function automatic logic [1:0] f_need(input logic [7:0] b);
      logic [1:0] n;
      n = 2'd0;
      if (!b[7])                    n = (b[5:4] == 2'b00) ? 2'd0 : 2'd1;
      else if (!b[6])               n = 2'd2;
      else if (b[5:4] == 2'b11) begin
         case (b[3:0])
            4'h2:       n = 2'd2;
            4'h3:       n = 2'd3;
            4'h4, 4'h5: n = 2'd1;
            default:    n = 2'd0;
         endcase
      end
      return n;
   endfunction

   // Sticky fault: push into a full stack or too few operands; CLR clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else if (exec_en) begin
         if (clr)
            fault_q <= 1'b0;
         else if ((inc && (depth_q == DEPTH_W'(STACK_DEPTH))) ||
                  (DEPTH_W'(f_need(op)) > depth_q))
            fault_q <= 1'b1;
      end
   end

   assign stack_fault = fault_q;
`endif

   assign bus.instr_ready = ready_q;
   assign bus.param_we    = pwe_q;
   assign bus.param_addr  = paddr_q;
   assign bus.param_data  = pdata_q;
   assign uo_out          = uo_q;
   assign sfr_out         = sfr_q;
   assign tos             = stk_q[0];
   assign stack_depth     = depth_q;

endmodule

// File: tb/tb_vslc_stack_executor.sv
// Scoreboard bench for vslc_stack_executor: a behavioural model computes the
// expected outputs for each driven cycle, pushes them to a queue, and the
// entry is popped and compared one cycle later.
module tb_vslc_stack_executor;
   localparam int SD  = 8;
   localparam int IOW = 8;
   localparam int SW  = 16;
   localparam int DW  = $clog2(SD + 1);

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           scan_start = 1'b0;
   logic [IOW-1:0] ui_in = '0;
   logic [SW-1:0]  sfr_in = '0;
   logic [IOW-1:0] uo_out;
   logic [SW-1:0]  sfr_out;
   logic           tos;
   logic [DW-1:0]  stack_depth;
`ifdef VSLC_STACK_FLAGS_EN
   logic           stack_fault;
`endif

   vslc_stack_executor_if bus ();

   always #5 clk = ~clk;

   vslc_stack_executor #(.STACK_DEPTH(SD), .IO_WIDTH(IOW), .SFR_WIDTH(SW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .scan_start  (scan_start),
      .ui_in       (ui_in),
      .sfr_in      (sfr_in),
      .uo_out      (uo_out),
      .sfr_out     (sfr_out),
      .tos         (tos),
      .stack_depth (stack_depth)
`ifdef VSLC_STACK_FLAGS_EN
      ,
      .stack_fault (stack_fault)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [SD-1:0]  ms;
   int             md;
   logic           mf;
   logic [IOW-1:0] mu, mimg, mprev;
   logic [SW-1:0]  msf;
   int             mst;          // 0 exec, 1 load, 2 skip
   logic [2:0]     mslot, mpa;
   logic [7:0]     mpd;
   logic           mpwe, mrdy;

   typedef struct packed {
      logic [IOW-1:0] uo;
      logic [SW-1:0]  sfr;
      logic           t;
      logic [DW-1:0]  d;
      logic           pwe;
      logic [2:0]     pa;
      logic [7:0]     pd;
      logic           rdy;
      logic           flt;
   } exp_t;

   exp_t sbq[$];

   task automatic m_reset();
      ms = '0; md = 0; mf = 1'b0; mu = '0; mimg = '0; mprev = '0; msf = '0;
      mst = 0; mslot = '0; mpa = '0; mpd = '0; mpwe = 1'b0; mrdy = 1'b0;
   endtask

   task automatic m_in(input logic b);
      for (int i = SD - 1; i > 0; i--) ms[i] = ms[i-1];
      ms[0] = b;
   endtask

   task automatic m_out();
      for (int i = 0; i < SD - 1; i++) ms[i] = ms[i+1];
      ms[SD-1] = 1'b0;
   endtask

   task automatic m_grow();
      if (md == SD) mf = 1'b1;
      else md++;
   endtask

   task automatic m_shrink();
      if (md > 0) md--;
   endtask

   task automatic m_need(input int k);
      if (k > md) mf = 1'b1;
   endtask

   function automatic logic m_wr(input logic [1:0] oo, input logic old, input logic t);
      if (oo == 2'b01) return t;
      if (oo == 2'b10) return t ? 1'b1 : old;
      return t ? 1'b0 : old;
   endfunction

   task automatic m_exec(input logic [7:0] b);
      logic t, n, r, bv, tmp;
      logic [3:0] tt;
      int idx;
      t = ms[0];
      n = ms[1];
      if (b[7] == 1'b0) begin
         if (b[6]) idx = int'(b[3:0]);
         else      idx = int'(b[2:0]);
         if (b[5:4] == 2'b00) begin
            if (b[6]) bv = (idx < SW) ? sfr_in[idx] : 1'b0;
            else      bv = (idx < IOW) ? (b[3] ? mu[idx] : mimg[idx]) : 1'b0;
            m_grow();
            m_in(bv);
         end else begin
            m_need(1);
            if (b[6]) begin
               if (idx < SW) msf[idx] = m_wr(b[5:4], msf[idx], t);
            end else begin
               if (idx < IOW) mu[idx] = m_wr(b[5:4], mu[idx], t);
            end
            m_out();
            m_shrink();
         end
      end else if (b[7:6] == 2'b10) begin
         m_need(2);
         tt  = b[3:0];
         idx = 3 - 2 * int'(n) - int'(t);
         r   = tt[idx[1:0]];
         case (b[5:4])
            2'b01: begin m_out(); m_out(); m_in(r); m_shrink(); end
            2'b11: begin m_grow(); m_in(r); end
            default: ms[0] = r;
         endcase
      end else if (b[7:5] == 3'b110) begin
         idx = int'(b[2:0]);
         bv  = (idx < IOW) && (mimg[idx] == !b[4]) && (mprev[idx] == b[4]);
         m_grow();
         m_in(bv);
      end else if (b[7:4] == 4'b1110) begin
         mst   = (t == b[3]) ? 1 : 2;
         mslot = b[2:0];
      end else begin
         case (b[3:0])
            4'h0: begin ms = '0; md = 0; mf = 1'b0; end
            4'h1: begin ms = '1; md = SD; end
            4'h2: begin m_need(2); ms[0] = n; ms[1] = t; end
            4'h3: begin m_need(3); tmp = ms[2]; ms[0] = n; ms[1] = tmp; ms[2] = t; end
            4'h4: begin m_need(1); m_grow(); m_in(t); end
            4'h5: begin m_need(1); m_out(); m_shrink(); end
            default: ;
         endcase
      end
   endtask

   task automatic m_cycle(input logic v, input logic [7:0] b, input logic sc);
      mpwe = 1'b0;
      if (v && mrdy) begin
         if (mst == 1) begin
            mpwe = 1'b1; mpa = mslot; mpd = b; mst = 0;
         end else if (mst == 2) begin
            mst = 0;
         end else begin
            m_exec(b);
         end
      end
      if (sc) begin
         mprev = mimg;
         mimg  = ui_in;
      end
      mrdy = 1'b1;
   endtask

   // Drive one cycle of stimulus, queue the model's prediction, compare after the edge.
   task automatic step(input logic v, input logic [7:0] b, input logic sc);
      exp_t e, g;
      bus.instr_valid = v;
      bus.instr       = b;
      scan_start      = sc;
      m_cycle(v, b, sc);
      e.uo = mu; e.sfr = msf; e.t = ms[0]; e.d = DW'(md); e.pwe = mpwe;
      e.pa = mpa; e.pd = mpd; e.rdy = mrdy; e.flt = mf;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      g = sbq.pop_front();
      check("uo_out",      uo_out,          g.uo);
      check("sfr_out",     sfr_out,         g.sfr);
      check("tos",         tos,             g.t);
      check("stack_depth", stack_depth,     g.d);
      check("param_we",    bus.param_we,    g.pwe);
      check("param_addr",  bus.param_addr,  g.pa);
      check("param_data",  bus.param_data,  g.pd);
      check("instr_ready", bus.instr_ready, g.rdy);
`ifdef VSLC_STACK_FLAGS_EN
      check("stack_fault", stack_fault,     g.flt);
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_uo"},    uo_out,          0);
      check({tag, "_sfr"},   sfr_out,         0);
      check({tag, "_tos"},   tos,             0);
      check({tag, "_depth"}, stack_depth,     0);
      check({tag, "_we"},    bus.param_we,    0);
      check({tag, "_addr"},  bus.param_addr,  0);
      check({tag, "_data"},  bus.param_data,  0);
      check({tag, "_rdy"},   bus.instr_ready, 0);
`ifdef VSLC_STACK_FLAGS_EN
      check({tag, "_fault"}, stack_fault,     0);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = 8'h00;
      sfr_in          = 16'hA5C3;
      m_reset();
      #1 rst = 1'b1;
      #11;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 8'h01, 1'b0);      // not accepted: ready rises at this edge
      check("ready_rise", bus.instr_ready, 1);
      check("ready_noexec_depth", stack_depth, 0);

      // AND / OR of image bits 0,1 written to output 2
      ui_in = 8'b10;
      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h91, 1'b0);
      step(1'b1, 8'h12, 1'b0);
      check("and_uo", uo_out, 8'h00);
      check("and_depth", stack_depth, 0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h97, 1'b0);
      step(1'b1, 8'h12, 1'b0);
      check("or_uo", uo_out, 8'h04);

      // Rising-edge detect on input 0
      ui_in = 8'h00;
      step(1'b0, 8'h00, 1'b1);
      ui_in = 8'h01;
      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'hC0, 1'b0);
      check("edge_rise", tos, 1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'hC0, 1'b0);
      check("edge_none", tos, 0);

      // Simultaneous scan_start and edge test uses the old image
      ui_in = 8'h00;
      step(1'b1, 8'hD0, 1'b1);       // falling test on old prev=1,img=1 -> 0

      // Parameter load and skip
      step(1'b1, 8'hF0, 1'b0);
      step(1'b1, 8'hF1, 1'b0);
      step(1'b1, 8'hE9, 1'b0);
      step(1'b1, 8'h37, 1'b0);
      check("pload_we", bus.param_we, 1);
      check("pload_addr", bus.param_addr, 1);
      check("pload_data", bus.param_data, 8'h37);
      check("pload_depth", stack_depth, SD);
      step(1'b0, 8'h00, 1'b0);
      check("pload_once", bus.param_we, 0);
      step(1'b1, 8'hF0, 1'b0);
      step(1'b1, 8'hE9, 1'b0);
      step(1'b1, 8'h05, 1'b0);
      check("pskip_we", bus.param_we, 0);
      check("pskip_depth", stack_depth, 0);

      // ROT and DUP
      ui_in = 8'b10;
      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'hF3, 1'b0);
      check("rot_tos", tos, 1);
      step(1'b1, 8'hF4, 1'b0);
      check("dup_depth", stack_depth, 4);
      check("dup_tos", tos, 1);
      step(1'b1, 8'hF5, 1'b0);
      step(1'b1, 8'hF5, 1'b0);
      check("rot_nos", tos, 0);
      step(1'b1, 8'hF5, 1'b0);
      check("rot_s2", tos, 1);

      // Overflow, underflow, CLR
      step(1'b1, 8'hF0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, 8'h01, 1'b0);
      check("ovf_depth", stack_depth, SD);
`ifdef VSLC_STACK_FLAGS_EN
      check("ovf_fault", stack_fault, 1);
`endif
      for (int i = 0; i < 9; i++) step(1'b1, 8'hF5, 1'b0);
      check("drop_empty_depth", stack_depth, 0);
      step(1'b1, 8'hF0, 1'b0);
`ifdef VSLC_STACK_FLAGS_EN
      check("clr_fault", stack_fault, 0);
`endif

      // Randomised instruction stream
      for (int i = 0; i < 600; i++) begin
         ui_in  = IOW'($urandom);
         sfr_in = SW'($urandom);
         step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0);
      end

      // Asynchronous reset in the middle of a parameter load
      step(1'b1, 8'hF1, 1'b0);
      step(1'b1, 8'hE9, 1'b0);
      bus.instr_valid = 1'b1;
      bus.instr       = 8'h37;
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("async");
      @(posedge clk);
      #1;
      check("async_hold_we", bus.param_we, 0);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      step(1'b1, 8'h37, 1'b0);
      step(1'b1, 8'h37, 1'b0);
      check("async_no_strobe", bus.param_we, 0);
      step(1'b0, 8'h00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
